// File: rtl/io_bridge.sv
// Device-side bridge between the CPU in/out ports and byte-wide valid/ready streams.
// Outbound words pass through a small FIFO and are serialised LSB first; inbound bytes are assembled into words.
module io_bridge #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] out_word,
  input  logic        out_strobe,
  output logic [31:0] in_word,
  output logic        in_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic {RX_COLLECT, RX_PRESENT} rx_state_e;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  tx_state_e     tx_state_q, tx_state_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [23:0]   asm_q, asm_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   in_word_q, in_word_d;

  // TX: pop on entry from IDLE, or on the edge that accepts byte 3 so words stream without a bubble
  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          idx_d      = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[{idx_q, 3'b000} +: 8];
        if (tx_ready) begin
          if (idx_q == 2'd3) begin
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              idx_d   = '0;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = out_strobe && ((count_q != DEPTH_C) || pop);
    overflow_d = overflow_q || (out_strobe && !push);
    if (push) begin
      mem_d[wr_ptr_q] = out_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // RX: the first three bytes shift in from the top, so after three they sit little-endian in asm_q
  always_comb begin
    rx_state_d = rx_state_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    in_word_d  = in_word_q;
    rx_ready   = 1'b0;
    in_en      = 1'b0;
    unique case (rx_state_q)
      RX_COLLECT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (cnt_q == 2'd3) begin
            in_word_d  = {rx_data, asm_q};
            cnt_d      = '0;
            rx_state_d = RX_PRESENT;
          end else begin
            asm_d = {rx_data, asm_q[23:8]};
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      RX_PRESENT: begin
        in_en      = 1'b1;
        rx_state_d = RX_COLLECT;
      end
      default: rx_state_d = RX_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      rx_state_q <= RX_COLLECT;
      asm_q      <= '0;
      cnt_q      <= '0;
      in_word_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_state_q <= tx_state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      rx_state_q <= rx_state_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      in_word_q  <= in_word_d;
    end
  end

  assign in_word  = in_word_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: vector table, directed corner sequences and a
// randomized run against a queue-based transaction model.
module tb_io_bridge;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] out_word;
  logic        out_strobe;
  logic [31:0] in_word;
  logic        in_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        overflow;

  io_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .out_word(out_word), .out_strobe(out_strobe),
    .in_word(in_word), .in_en(in_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  rx [4];
    logic [7:0]  tx_exp [4];
    logic [31:0] in_exp;
  } vec_t;

  vec_t vecs [3];

  // reference model state: words waiting, word being sent, bytes already accepted
  logic [31:0] mq [$];
  logic [31:0] m_cur;
  bit          m_busy;
  int          m_sent;
  bit          m_ovf;
  logic [7:0]  rxq [$];
  logic [31:0] m_in_word;
  bit          m_present;
  bit          model_on = 0;

  logic [7:0]  got_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rxq.delete();
    m_cur = '0; m_busy = 0; m_sent = 0; m_ovf = 0;
    m_in_word = '0; m_present = 0;
  endtask

  task automatic model_update();
    bit fire, pop, accept;
    fire = m_busy && tx_ready;
    pop  = 0;
    if (!m_busy) pop = (mq.size() > 0);
    else if (fire && m_sent == 3) pop = (mq.size() > 0);
    accept = out_strobe && ((mq.size() < DEPTH) || pop);
    if (fire) begin
      m_sent++;
      if (m_sent == 4) m_busy = 0;
    end
    if (pop) begin
      m_cur = mq.pop_front();
      m_busy = 1;
      m_sent = 0;
    end
    if (accept) mq.push_back(out_word);
    else if (out_strobe) m_ovf = 1;
    if (m_present) m_present = 0;
    else if (rx_valid) begin
      rxq.push_back(rx_data);
      if (rxq.size() == 4) begin
        m_in_word = {rxq[3], rxq[2], rxq[1], rxq[0]};
        rxq.delete();
        m_present = 1;
      end
    end
  endtask

  task automatic step();
    if (model_on) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    out_strobe = 0; out_word = '0; tx_ready = 0; rx_valid = 0; rx_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 0;
    repeat (2) @(posedge clk);
    #1 clr = 1;
    model_reset();
  endtask

  // records every byte handed over during a fixed window, extras included
  task automatic collect(input int budget);
    got_q.delete();
    tx_ready = 1;
    for (int c = 0; c < budget; c++) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      step();
    end
  endtask

  task automatic chk_words(input string name, input logic [31:0] exp_w [$]);
    chk({name, "_count"}, got_q.size(), exp_w.size() * 4);
    for (int w = 0; w < exp_w.size(); w++) begin
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < got_q.size())
          chk($sformatf("%s_w%0d_b%0d", name, w, b), got_q[w*4+b], (exp_w[w] >> (8 * b)) & 32'hFF);
      end
    end
  endtask

  initial begin
    logic [31:0] exp_w [$];
    logic [7:0]  s2_data [7];
    bit          s2_ready [7];

    vecs[0] = '{32'hDEADBEEF, '{8'h78, 8'h56, 8'h34, 8'h12}, '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, 32'h12345678};
    vecs[1] = '{32'h01234567, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, '{8'h67, 8'h45, 8'h23, 8'h01}, 32'hDDCCBBAA};
    vecs[2] = '{32'h80000001, '{8'hFF, 8'h00, 8'hFF, 8'h00}, '{8'h01, 8'h00, 8'h00, 8'h80}, 32'h00FF00FF};

    // reset values
    do_reset();
    chk("rst_in_word", in_word, 0);
    chk("rst_in_en", in_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_overflow", overflow, 0);

    // vector table: word out and word in concurrently
    tx_ready = 1;
    for (int v = 0; v < 3; v++) begin
      out_word = vecs[v].word; out_strobe = 1;
      step();
      out_strobe = 0;
      chk($sformatf("v%0d_n1_valid", v), tx_valid, 0);
      for (int k = 0; k < 4; k++) begin
        rx_valid = 1; rx_data = vecs[v].rx[k];
        step();
        chk($sformatf("v%0d_valid%0d", v, k), tx_valid, 1);
        chk($sformatf("v%0d_byte%0d", v, k), tx_data, vecs[v].tx_exp[k]);
      end
      rx_valid = 0;
      chk($sformatf("v%0d_in_en", v), in_en, 1);
      chk($sformatf("v%0d_in_word", v), in_word, vecs[v].in_exp);
      chk($sformatf("v%0d_rx_ready_lo", v), rx_ready, 0);
      step();
      chk($sformatf("v%0d_tx_done", v), tx_valid, 0);
      chk($sformatf("v%0d_in_en_off", v), in_en, 0);
      chk($sformatf("v%0d_in_word_hold", v), in_word, vecs[v].in_exp);
      chk($sformatf("v%0d_rx_ready_hi", v), rx_ready, 1);
    end

    // stall while byte 1 is presented
    s2_data  = '{8'hEF, 8'hBE, 8'hBE, 8'hBE, 8'hBE, 8'hAD, 8'hDE};
    s2_ready = '{1, 0, 0, 0, 1, 1, 1};
    out_word = 32'hDEADBEEF; out_strobe = 1; tx_ready = 1;
    step();
    out_strobe = 0;
    step();
    for (int c = 0; c < 7; c++) begin
      tx_ready = s2_ready[c];
      chk($sformatf("stall_valid%0d", c), tx_valid, 1);
      chk($sformatf("stall_data%0d", c), tx_data, s2_data[c]);
      step();
    end
    chk("stall_done", tx_valid, 0);

    // overflow: the first word moves into the shift register, so the sixth is the first dropped
    do_reset();
    for (int w = 1; w <= 6; w++) begin
      out_word = w; out_strobe = 1;
      step();
    end
    out_strobe = 0;
    chk("ovf_set", overflow, 1);
    collect(40);
    exp_w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    chk_words("ovf_order", exp_w);
    chk("ovf_sticky", overflow, 1);
    clr = 0; #1;
    chk("ovf_clr", overflow, 0);
    #1 clr = 1;

    // push into a full FIFO on the edge that pops it
    do_reset();
    for (int w = 1; w <= 5; w++) begin
      out_word = 32'h0A0B0C00 + w; out_strobe = 1;
      step();
    end
    out_strobe = 0;
    chk("full_no_ovf", overflow, 0);
    tx_ready = 1;
    repeat (3) step();
    chk("full_last_byte", tx_data, 8'h0A);
    out_word = 32'h00000066; out_strobe = 1;
    step();
    out_strobe = 0;
    chk("full_pop_push_ovf", overflow, 0);
    collect(40);
    exp_w = '{32'h0A0B0C02, 32'h0A0B0C03, 32'h0A0B0C04, 32'h0A0B0C05, 32'h00000066};
    chk_words("full_order", exp_w);

    // reset in the middle of RX and TX activity
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1; rx_data = 8'hC0 + 8'(k);
      step();
    end
    rx_valid = 0;
    step();
    chk("mid_pre_word", in_word, 32'hC3C2C1C0);
    out_word = 32'h55667788; out_strobe = 1;
    rx_valid = 1; rx_data = 8'hAA;
    step();
    out_word = 32'h99AABBCC; rx_data = 8'hBB;
    step();
    out_strobe = 0; rx_valid = 0; tx_ready = 1;
    step();
    tx_ready = 0;
    step();
    chk("mid_tx_busy", tx_valid, 1);
    clr = 0; #1;
    chk("mid_in_word", in_word, 0);
    chk("mid_in_en", in_en, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_tx_valid", tx_valid, 0);
    chk("mid_rx_ready", rx_ready, 1);
    chk("mid_overflow", overflow, 0);
    @(posedge clk); #1 clr = 1;
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1; rx_data = 8'h04 - 8'(k);
      step();
    end
    rx_valid = 0;
    chk("mid_after_in_en", in_en, 1);
    chk("mid_after_word", in_word, 32'h01020304);
    collect(12);
    chk("mid_fifo_dropped", got_q.size(), 0);

    // randomized traffic against the model, light then heavy outbound load
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      model_on = 1;
      for (int c = 0; c < 1500; c++) begin
        out_strobe = ($urandom_range(0, 99) < (phase == 0 ? 10 : 35));
        out_word   = $urandom;
        tx_ready   = ($urandom_range(0, 99) < 60);
        rx_valid   = ($urandom_range(0, 99) < 50);
        rx_data    = 8'($urandom);
        step();
        chk("rnd_tx_valid", tx_valid, m_busy);
        if (m_busy) chk("rnd_tx_data", tx_data, (m_cur >> (8 * m_sent)) & 32'hFF);
        chk("rnd_in_en", in_en, m_present);
        chk("rnd_rx_ready", rx_ready, !m_present);
        chk("rnd_in_word", in_word, m_in_word);
        chk("rnd_overflow", overflow, m_ovf);
      end
      model_on = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
